tlul_mem_master: RTL and testbench
==================================

Name: tlul_mem_master

Overview:
- Parametrised second-generation TileLink-UL master for the processor's memory stage.
- Accepts load/store requests from the pipeline through a valid/ready port and issues Get, PutFullData or PutPartialData beats on the A channel.
- Keeps up to 2**SRC_W transactions outstanding, one per source ID. Retries errored responses up to MAX_RETRY times.
- Returns aligned, sign- or zero-extended load data to the pipeline.

Parameters:
- ADDR_W, 10, address field width
- DATA_W, 32, data width in bits; must be 32 (byte lanes = DATA_W/8)
- SRC_W, 2, source ID width; outstanding depth is 2**SRC_W
- MAX_RETRY, 2, re-issues allowed per transaction after an errored response

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  pipeline request valid
- req_ready  out  1  request accepted this cycle when high together with req_valid
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V funct3 (size and sign)
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  store data, right-aligned
- a_valid  out  1  A beat valid
- a_ready  in  1  slave accepts A beat
- a_channel  out  12+SRC_W+ADDR_W+DATA_W/8+DATA_W  {opcode[3],param[3],size[3],source,address,mask,data}
- d_valid  in  1  D beat valid
- d_ready  out  1  master accepts D beat
- d_channel  in  10+SRC_W+DATA_W  {opcode[3],param[3],size[3],source,error[1],data}
- resp_valid  out  1  one-cycle completion pulse
- resp_source  out  SRC_W  completed source ID
- resp_rdata  out  DATA_W  extended load data; 0 for stores
- resp_error  out  1  completion failed
- busy  out  1  any slot outstanding or retry pending
- spurious  out  1  one-cycle pulse: D beat for a source that is not outstanding

Behaviour:
- Reset: a_valid, d_ready, resp_valid, resp_error, spurious, busy = 0; a_channel = 0; all slots free; retry counters = 0. d_ready rises the cycle after reset deasserts.
- Slot table: one entry per source, holding valid, retry_pend, retry_cnt, we, funct3, addr[1:0] and the full A beat.
- Encoding:
  - size = log2 bytes: lb/lbu/sb = 0, lh/lhu/sh = 1, lw/sw = 2.
  - param = 0.
  - opcode: load = 4 (Get); word store = 0 (PutFullData); byte/half store = 1 (PutPartialData).
  - mask: byte = 1<<addr[1:0]; half = 3<<{addr[1],1'b0}; word = 4'hF.
  - Store data is replicated across all lanes.
- Illegal request: funct3 not in {0,1,2,4,5} for loads or {0,1,2} for stores, or address misaligned to its size.
  - The request is accepted, but no A beat is issued.
  - err_pend is set, and resp_valid=1 with resp_error=1 follows on the next cycle.
  - d_ready=0 while err_pend is set.
- A issue:
  - Once a_valid=1, a_channel is held stable until a_valid && a_ready.
  - When A is idle or completing, the next beat is chosen in priority order: lowest-index retry_pend slot first, then a new request into the lowest free slot.
  - req_ready = free slot exists && no retry_pend && !err_pend && (!a_valid || a_ready).
  - Accepted requests load a_channel on the next edge.
- D handling, on d_valid && d_ready with slot[source].valid:
  - error=0: slot freed; resp_valid pulse with resp_error=0. resp_rdata is lane-shifted by addr[1:0] and sign-extended (funct3 0,1) or zero-extended (funct3 4,5); word passes through; stores give 0.
  - error=1 and retry_cnt < MAX_RETRY: retry_cnt++, retry_pend=1, no resp.
  - error=1 and retry_cnt = MAX_RETRY: slot freed; resp with resp_error=1.
- D beat for a free slot: dropped, spurious pulse, no state change.
- Simultaneous events: a slot freed by D in cycle N may be reallocated by a request no earlier than cycle N+1. D completion and A issue for different slots proceed in the same cycle.
- Full: with all 2**SRC_W slots valid, req_ready=0 and no A issue except retries.
- Reset mid-operation: all state is dropped. Later D beats for old sources produce spurious pulses.

Decomposition:
- Package tlul_pkg holds:
  - opcode constants (GET=4, PUT_FULL=0, PUT_PARTIAL=1, ACK=0, ACK_DATA=1)
  - funct3 constants
  - field offset/width functions of SRC_W, ADDR_W and DATA_W
- Sub-module tlul_lane_align, purely combinational: funct3 + addr[1:0] -> size, mask, legal flag, replicated wdata; plus read extract/extend.

Test Plan:
- Single lw, addr 0x010, slave returns data 0xDEADBEEF no error -> A beat opcode 4, size 2, source 0, mask F. resp_valid with resp_rdata 0xDEADBEEF, resp_error 0.
- lb at addr 0x003, D data 0x80XXXXXX -> mask 4'h8, resp_rdata 0xFFFFFF80. Same request with lbu -> 0x00000080.
- sh at 0x006 with wdata 0x1234 -> opcode 1, mask 4'hC, data 0x12341234. Ack -> resp_rdata 0.
- Four back-to-back sw with a_ready always high, D withheld -> sources 0..3 issued. Fifth request sees req_ready=0. Ack source 2 -> next request takes source 2 one cycle later.
- MAX_RETRY=2, slave errors on source 1 three times -> A beat for source 1 re-issued exactly twice, then a single resp with resp_error=1. Errors on two tries then success -> resp_error=0.
- lw at addr 0x002 -> no A beat, resp_error=1 on the next cycle, d_ready low for that cycle. D beat for an idle source 3 -> spurious pulse, no resp. Reset asserted with 2 outstanding -> all outputs 0, busy 0.

Source files
------------

// File: rtl/tlul_pkg.sv
// ============================================================================
// Module      : tlul_pkg
// Description : TileLink-UL opcodes, RISC-V funct3 codes and channel layout.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tlul_pkg;

    localparam logic [2:0] c_op_get         = 3'd4;
    localparam logic [2:0] c_op_put_full    = 3'd0;
    localparam logic [2:0] c_op_put_partial = 3'd1;
    localparam logic [2:0] c_op_ack         = 3'd0;
    localparam logic [2:0] c_op_ack_data    = 3'd1;

    localparam logic [2:0] c_f3_b  = 3'd0;
    localparam logic [2:0] c_f3_h  = 3'd1;
    localparam logic [2:0] c_f3_w  = 3'd2;
    localparam logic [2:0] c_f3_bu = 3'd4;
    localparam logic [2:0] c_f3_hu = 3'd5;

    // A channel, LSB first: data, mask, address, source, size, param,
    // opcode, then three reserved zero bits at the top.
    function automatic int a_mask_lo(input int dw);
        return dw;
    endfunction
    function automatic int a_addr_lo(input int dw);
        return dw + dw / 8;
    endfunction
    function automatic int a_src_lo(input int aw, input int dw);
        return a_addr_lo(dw) + aw;
    endfunction
    function automatic int a_size_lo(input int sw, input int aw, input int dw);
        return a_src_lo(aw, dw) + sw;
    endfunction
    function automatic int a_param_lo(input int sw, input int aw, input int dw);
        return a_size_lo(sw, aw, dw) + 3;
    endfunction
    function automatic int a_op_lo(input int sw, input int aw, input int dw);
        return a_param_lo(sw, aw, dw) + 3;
    endfunction
    function automatic int a_width(input int sw, input int aw, input int dw);
        return a_op_lo(sw, aw, dw) + 6;
    endfunction

    // D channel, LSB first: data, error, source, size, param, opcode.
    function automatic int d_err_bit(input int dw);
        return dw;
    endfunction
    function automatic int d_src_lo(input int dw);
        return dw + 1;
    endfunction
    function automatic int d_size_lo(input int sw, input int dw);
        return d_src_lo(dw) + sw;
    endfunction
    function automatic int d_op_lo(input int sw, input int dw);
        return d_size_lo(sw, dw) + 6;
    endfunction
    function automatic int d_width(input int sw, input int dw);
        return d_op_lo(sw, dw) + 3;
    endfunction

endpackage

`default_nettype wire

// File: rtl/tlul_lane_align.sv
// ============================================================================
// Module      : tlul_lane_align
// Description : Byte-lane helper: request size/mask/legality/store replication
//               and load data extraction with sign/zero extension.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tlul_lane_align
    import tlul_pkg::*;
(
    input  logic        i_we,
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    output logic [2:0]  o_size,
    output logic [3:0]  o_mask,
    output logic        o_legal,
    output logic [31:0] o_wdata,
    input  logic [2:0]  i_rd_funct3,
    input  logic [1:0]  i_rd_addr_lo,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_rdata
);

    logic [31:0] w_shift;

    always_comb begin
        o_size  = {1'b0, i_funct3[1:0]};
        o_mask  = 4'hF;
        o_wdata = i_wdata;
        o_legal = 1'b0;
        case (i_funct3[1:0])
            2'd0: begin
                o_mask  = 4'b0001 << i_addr_lo;
                o_wdata = {4{i_wdata[7:0]}};
            end
            2'd1: begin
                o_mask  = i_addr_lo[1] ? 4'hC : 4'h3;
                o_wdata = {2{i_wdata[15:0]}};
            end
            default: begin
                o_mask  = 4'hF;
                o_wdata = i_wdata;
            end
        endcase
        case (i_funct3)
            c_f3_b:  o_legal = 1'b1;
            c_f3_h:  o_legal = !i_addr_lo[0];
            c_f3_w:  o_legal = (i_addr_lo == 2'b00);
            c_f3_bu: o_legal = !i_we;
            c_f3_hu: o_legal = !i_we && !i_addr_lo[0];
            default: o_legal = 1'b0;
        endcase
    end

    assign w_shift = i_rdata >> {i_rd_addr_lo, 3'b000};

    always_comb begin
        case (i_rd_funct3[1:0])
            2'd0:    o_rdata = i_rd_funct3[2] ? {24'b0, w_shift[7:0]}
                                              : {{24{w_shift[7]}}, w_shift[7:0]};
            2'd1:    o_rdata = i_rd_funct3[2] ? {16'b0, w_shift[15:0]}
                                              : {{16{w_shift[15]}}, w_shift[15:0]};
            default: o_rdata = i_rdata;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/tlul_mem_master.sv
// ============================================================================
// Module      : tlul_mem_master
// Description : TileLink-UL master for the memory stage; one outstanding
//               transaction per source ID with bounded error retry.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tlul_mem_master
    import tlul_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 32,
    parameter int SRC_W     = 2,
    parameter int MAX_RETRY = 2
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      req_valid,
    output logic                                      req_ready,
    input  logic                                      req_we,
    input  logic [2:0]                                req_funct3,
    input  logic [ADDR_W-1:0]                         req_addr,
    input  logic [DATA_W-1:0]                         req_wdata,
    output logic                                      a_valid,
    input  logic                                      a_ready,
    output logic [12+SRC_W+ADDR_W+DATA_W/8+DATA_W-1:0] a_channel,
    input  logic                                      d_valid,
    output logic                                      d_ready,
    input  logic [10+SRC_W+DATA_W-1:0]                d_channel,
    output logic                                      resp_valid,
    output logic [SRC_W-1:0]                          resp_source,
    output logic [DATA_W-1:0]                         resp_rdata,
    output logic                                      resp_error,
    output logic                                      busy,
    output logic                                      spurious
);

    localparam int NSLOT      = 1 << SRC_W;
    localparam int AW_W       = a_width(SRC_W, ADDR_W, DATA_W);
    localparam int A_MASK_LO  = a_mask_lo(DATA_W);
    localparam int A_ADDR_LO  = a_addr_lo(DATA_W);
    localparam int A_SRC_LO   = a_src_lo(ADDR_W, DATA_W);
    localparam int A_SIZE_LO  = a_size_lo(SRC_W, ADDR_W, DATA_W);
    localparam int A_OP_LO    = a_op_lo(SRC_W, ADDR_W, DATA_W);
    localparam int D_ERR_BIT  = d_err_bit(DATA_W);
    localparam int D_SRC_LO   = d_src_lo(DATA_W);
    localparam int RC_W       = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [RC_W-1:0] c_max_retry = RC_W'(MAX_RETRY);

    logic [NSLOT-1:0]  r_vld;
    logic [NSLOT-1:0]  r_rpend;
    logic [RC_W-1:0]   r_rcnt  [NSLOT];
    logic              r_we    [NSLOT];
    logic [2:0]        r_f3    [NSLOT];
    logic [1:0]        r_alo   [NSLOT];
    logic [AW_W-1:0]   r_beat  [NSLOT];

    logic              r_a_valid;
    logic [AW_W-1:0]   r_a_channel;
    logic              r_d_en;
    logic              r_err_pend;
    logic              r_err_sent;
    logic              r_resp_valid;
    logic [SRC_W-1:0]  r_resp_source;
    logic [DATA_W-1:0] r_resp_rdata;
    logic              r_resp_error;
    logic              r_spurious;

    logic              w_free_any;
    logic [SRC_W-1:0]  w_free_idx;
    logic              w_rp_any;
    logic [SRC_W-1:0]  w_rp_idx;
    logic              w_a_free;
    logic              w_req_fire;
    logic [2:0]        w_size;
    logic [3:0]        w_mask;
    logic              w_legal;
    logic [DATA_W-1:0] w_wdata;
    logic [2:0]        w_opcode;
    logic [AW_W-1:0]   w_new_beat;
    logic              w_d_fire;
    logic [SRC_W-1:0]  w_d_src;
    logic              w_d_err;
    logic [DATA_W-1:0] w_d_data;
    logic [DATA_W-1:0] w_rd_ext;
    logic              w_d_final;
    logic              w_d_resp;

    // Descending scan so the lowest index wins.
    always_comb begin
        w_free_any = 1'b0;
        w_free_idx = '0;
        w_rp_any   = 1'b0;
        w_rp_idx   = '0;
        for (int i = NSLOT - 1; i >= 0; i--) begin
            if (!r_vld[i]) begin
                w_free_any = 1'b1;
                w_free_idx = SRC_W'(i);
            end
            if (r_rpend[i]) begin
                w_rp_any = 1'b1;
                w_rp_idx = SRC_W'(i);
            end
        end
    end

    assign w_a_free   = !r_a_valid || a_ready;
    assign req_ready  = w_free_any && !w_rp_any && !r_err_pend && w_a_free;
    assign w_req_fire = req_valid && req_ready;

    assign w_d_fire = d_valid && d_ready;
    assign w_d_src  = d_channel[D_SRC_LO +: SRC_W];
    assign w_d_err  = d_channel[D_ERR_BIT];
    assign w_d_data = d_channel[DATA_W-1:0];

    assign w_d_final = !w_d_err || (r_rcnt[w_d_src] >= c_max_retry);
    assign w_d_resp  = w_d_fire && r_vld[w_d_src] && w_d_final;

    tlul_lane_align u_lane_align (
        .i_we         (req_we),
        .i_funct3     (req_funct3),
        .i_addr_lo    (req_addr[1:0]),
        .i_wdata      (req_wdata),
        .o_size       (w_size),
        .o_mask       (w_mask),
        .o_legal      (w_legal),
        .o_wdata      (w_wdata),
        .i_rd_funct3  (r_f3[w_d_src]),
        .i_rd_addr_lo (r_alo[w_d_src]),
        .i_rdata      (w_d_data),
        .o_rdata      (w_rd_ext)
    );

    always_comb begin
        if (!req_we) begin
            w_opcode = c_op_get;
        end else if (w_size == 3'd2) begin
            w_opcode = c_op_put_full;
        end else begin
            w_opcode = c_op_put_partial;
        end
        w_new_beat                          = '0;
        w_new_beat[A_OP_LO +: 3]            = w_opcode;
        w_new_beat[A_SIZE_LO +: 3]          = w_size;
        w_new_beat[A_SRC_LO +: SRC_W]       = w_free_idx;
        w_new_beat[A_ADDR_LO +: ADDR_W]     = req_addr;
        w_new_beat[A_MASK_LO +: DATA_W/8]   = w_mask;
        w_new_beat[DATA_W-1:0]              = w_wdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_vld         <= '0;
            r_rpend       <= '0;
            for (int i = 0; i < NSLOT; i++) begin
                r_rcnt[i] <= '0;
                r_we[i]   <= 1'b0;
                r_f3[i]   <= 3'd0;
                r_alo[i]  <= 2'd0;
                r_beat[i] <= '0;
            end
            r_a_valid     <= 1'b0;
            r_a_channel   <= '0;
            r_d_en        <= 1'b0;
            r_err_pend    <= 1'b0;
            r_err_sent    <= 1'b0;
            r_resp_valid  <= 1'b0;
            r_resp_source <= '0;
            r_resp_rdata  <= '0;
            r_resp_error  <= 1'b0;
            r_spurious    <= 1'b0;
        end else begin
            r_d_en       <= 1'b1;
            r_resp_valid <= 1'b0;
            r_spurious   <= 1'b0;

            if (w_a_free) begin
                if (w_rp_any) begin
                    r_a_valid         <= 1'b1;
                    r_a_channel       <= r_beat[w_rp_idx];
                    r_rpend[w_rp_idx] <= 1'b0;
                end else if (w_req_fire && w_legal) begin
                    r_a_valid           <= 1'b1;
                    r_a_channel         <= w_new_beat;
                    r_vld[w_free_idx]   <= 1'b1;
                    r_rpend[w_free_idx] <= 1'b0;
                    r_rcnt[w_free_idx]  <= '0;
                    r_we[w_free_idx]    <= req_we;
                    r_f3[w_free_idx]    <= req_funct3;
                    r_alo[w_free_idx]   <= req_addr[1:0];
                    r_beat[w_free_idx]  <= w_new_beat;
                end else begin
                    r_a_valid <= 1'b0;
                end
            end

            if (w_d_fire) begin
                if (!r_vld[w_d_src]) begin
                    r_spurious <= 1'b1;
                end else if (w_d_final) begin
                    r_vld[w_d_src] <= 1'b0;
                end else begin
                    r_rcnt[w_d_src]  <= r_rcnt[w_d_src] + 1'b1;
                    r_rpend[w_d_src] <= 1'b1;
                end
            end

            // An illegal request's error response yields to a same-cycle D
            // completion and goes out while err_pend holds D off.
            if (w_req_fire && !w_legal) begin
                r_err_pend <= 1'b1;
                r_err_sent <= !w_d_resp;
            end else begin
                r_err_pend <= 1'b0;
                r_err_sent <= 1'b0;
            end

            if (w_d_resp) begin
                r_resp_valid  <= 1'b1;
                r_resp_source <= w_d_src;
                r_resp_error  <= w_d_err;
                r_resp_rdata  <= (w_d_err || r_we[w_d_src]) ? '0 : w_rd_ext;
            end else if ((w_req_fire && !w_legal) || (r_err_pend && !r_err_sent)) begin
                r_resp_valid  <= 1'b1;
                r_resp_source <= '0;
                r_resp_error  <= 1'b1;
                r_resp_rdata  <= '0;
            end
        end
    end

    assign a_valid     = r_a_valid;
    assign a_channel   = r_a_channel;
    assign d_ready     = r_d_en && !r_err_pend;
    assign resp_valid  = r_resp_valid;
    assign resp_source = r_resp_source;
    assign resp_rdata  = r_resp_rdata;
    assign resp_error  = r_resp_error;
    assign spurious    = r_spurious;
    assign busy        = (|r_vld) || r_err_pend;

endmodule

`default_nettype wire

// File: tb/tb_tlul_mem_master.sv
// ============================================================================
// Module      : tb_tlul_mem_master
// Description : Directed self-checking bench for tlul_mem_master.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tlul_mem_master;

    localparam int ADDR_W    = 10;
    localparam int DATA_W    = 32;
    localparam int SRC_W     = 2;
    localparam int MAX_RETRY = 2;
    localparam int AW        = 60;
    localparam int DW        = 44;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_we = 1'b0;
    logic [2:0]        req_funct3 = 3'd0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [DATA_W-1:0] req_wdata = '0;
    logic              a_valid;
    logic              a_ready = 1'b1;
    logic [AW-1:0]     a_channel;
    logic              d_valid = 1'b0;
    logic              d_ready;
    logic [DW-1:0]     d_channel = '0;
    logic              resp_valid;
    logic [SRC_W-1:0]  resp_source;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_error;
    logic              busy;
    logic              spurious;

    int num_vec = 0;
    int num_err = 0;

    int          a_cnt [4] = '{0, 0, 0, 0};
    int          a_total   = 0;
    logic [1:0]  a_src_log [$];
    int          resp_cnt  = 0;
    logic [1:0]  last_rsrc = '0;
    logic [31:0] last_rdata = '0;
    logic        last_rerr = 1'b0;
    int          spur_cnt  = 0;

    tlul_mem_master #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .SRC_W     (SRC_W),
        .MAX_RETRY (MAX_RETRY)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_funct3  (req_funct3),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .a_valid     (a_valid),
        .a_ready     (a_ready),
        .a_channel   (a_channel),
        .d_valid     (d_valid),
        .d_ready     (d_ready),
        .d_channel   (d_channel),
        .resp_valid  (resp_valid),
        .resp_source (resp_source),
        .resp_rdata  (resp_rdata),
        .resp_error  (resp_error),
        .busy        (busy),
        .spurious    (spurious)
    );

    always #5 clk = ~clk;

    // Bus monitor: A beats fire at the next edge when valid and ready.
    always @(negedge clk) begin
        if (a_valid && a_ready) begin
            a_cnt[a_channel[47:46]]++;
            a_total++;
            a_src_log.push_back(a_channel[47:46]);
        end
        if (resp_valid) begin
            resp_cnt++;
            last_rsrc  = resp_source;
            last_rdata = resp_rdata;
            last_rerr  = resp_error;
        end
        if (spurious) spur_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic issue_req(input logic we, input logic [2:0] f3,
                             input logic [9:0] addr, input logic [31:0] wd);
        logic ok;
        req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        req_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (req_ready) ok = 1'b1;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        num_vec++;
        if (!ok) begin
            num_err++;
            $display("FAIL req_accept: req_ready=0 for 20 cycles, required 1");
        end
    endtask

    task automatic send_d(input logic [2:0] op, input logic [1:0] src,
                          input logic err, input logic [31:0] data);
        logic ok;
        d_channel = {op, 3'd0, 3'd2, src, err, data};
        d_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (d_ready) ok = 1'b1;
        end
        @(posedge clk);
        #1;
        d_valid = 1'b0;
        num_vec++;
        if (!ok) begin
            num_err++;
            $display("FAIL d_accept: d_ready=0 for 20 cycles, required 1");
        end
    endtask

    task automatic xact(input logic we, input logic [2:0] f3, input logic [9:0] addr,
                        input logic [31:0] wd, input logic [31:0] ddata,
                        output logic [59:0] beat, output logic got_a);
        issue_req(we, f3, addr, wd);
        got_a = 1'b0;
        beat  = '0;
        for (int i = 0; i < 10 && !got_a; i++) begin
            @(negedge clk);
            if (a_valid) begin
                got_a = 1'b1;
                beat  = a_channel;
            end
        end
        @(posedge clk);
        #1;
        send_d(we ? 3'd0 : 3'd1, beat[47:46], 1'b0, ddata);
        tick(1);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        num_vec++; if (a_valid !== 1'b0) begin num_err++; $display("FAIL rst_a_valid: got %b want 0", a_valid); end
        num_vec++; if (a_channel !== 60'd0) begin num_err++; $display("FAIL rst_a_channel: got %h want 0", a_channel); end
        num_vec++; if (d_ready !== 1'b0) begin num_err++; $display("FAIL rst_d_ready: got %b want 0", d_ready); end
        num_vec++; if (resp_valid !== 1'b0 || resp_error !== 1'b0) begin num_err++; $display("FAIL rst_resp: got v=%b e=%b want 0/0", resp_valid, resp_error); end
        num_vec++; if (busy !== 1'b0 || spurious !== 1'b0) begin num_err++; $display("FAIL rst_busy_spur: got %b/%b want 0/0", busy, spurious); end
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        num_vec++; if (d_ready !== 1'b0) begin num_err++; $display("FAIL rst_d_ready_early: got %b want 0", d_ready); end
        @(posedge clk);
        #1;
        @(negedge clk);
        num_vec++; if (d_ready !== 1'b1) begin num_err++; $display("FAIL rst_d_ready_rise: got %b want 1", d_ready); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_lw;
        logic [59:0] beat;
        logic        got;
        int          r0;
        r0 = resp_cnt;
        xact(1'b0, 3'd2, 10'h010, 32'h0, 32'hDEADBEEF, beat, got);
        num_vec++; if (got !== 1'b1) begin num_err++; $display("FAIL lw_a_seen: got %b want 1", got); end
        num_vec++; if (beat[56:54] !== 3'd4 || beat[50:48] !== 3'd2 || beat[53:51] !== 3'd0)
            begin num_err++; $display("FAIL lw_op_size_param: got %0d/%0d/%0d want 4/2/0", beat[56:54], beat[50:48], beat[53:51]); end
        num_vec++; if (beat[47:46] !== 2'd0 || beat[35:32] !== 4'hF || beat[45:36] !== 10'h010)
            begin num_err++; $display("FAIL lw_src_mask_addr: got %0d/%h/%h want 0/f/010", beat[47:46], beat[35:32], beat[45:36]); end
        num_vec++; if (resp_cnt !== r0 + 1 || last_rdata !== 32'hDEADBEEF || last_rerr !== 1'b0 || last_rsrc !== 2'd0)
            begin num_err++; $display("FAIL lw_resp: got n=%0d d=%h e=%b s=%0d want 1 deadbeef 0 0", resp_cnt - r0, last_rdata, last_rerr, last_rsrc); end
    endtask

    task automatic test_lb_lbu;
        logic [59:0] beat;
        logic        got;
        int          r0;
        r0 = resp_cnt;
        xact(1'b0, 3'd0, 10'h003, 32'h0, 32'h80123456, beat, got);
        num_vec++; if (got !== 1'b1 || beat[35:32] !== 4'h8 || beat[50:48] !== 3'd0)
            begin num_err++; $display("FAIL lb_mask: got a=%b mask=%h size=%0d want 1 8 0", got, beat[35:32], beat[50:48]); end
        num_vec++; if (resp_cnt !== r0 + 1 || last_rdata !== 32'hFFFFFF80)
            begin num_err++; $display("FAIL lb_rdata: got n=%0d d=%h want 1 ffffff80", resp_cnt - r0, last_rdata); end
        r0 = resp_cnt;
        xact(1'b0, 3'd4, 10'h003, 32'h0, 32'h80123456, beat, got);
        num_vec++; if (resp_cnt !== r0 + 1 || last_rdata !== 32'h00000080)
            begin num_err++; $display("FAIL lbu_rdata: got n=%0d d=%h want 1 00000080", resp_cnt - r0, last_rdata); end
    endtask

    task automatic test_sh;
        logic [59:0] beat;
        logic        got;
        int          r0;
        r0 = resp_cnt;
        xact(1'b1, 3'd1, 10'h006, 32'h00001234, 32'hFFFFFFFF, beat, got);
        num_vec++; if (got !== 1'b1 || beat[56:54] !== 3'd1 || beat[50:48] !== 3'd1 || beat[35:32] !== 4'hC)
            begin num_err++; $display("FAIL sh_hdr: got a=%b op=%0d size=%0d mask=%h want 1 1 1 c", got, beat[56:54], beat[50:48], beat[35:32]); end
        num_vec++; if (beat[31:0] !== 32'h12341234)
            begin num_err++; $display("FAIL sh_data: got %h want 12341234", beat[31:0]); end
        num_vec++; if (resp_cnt !== r0 + 1 || last_rdata !== 32'h0 || last_rerr !== 1'b0)
            begin num_err++; $display("FAIL sh_resp: got n=%0d d=%h e=%b want 1 0 0", resp_cnt - r0, last_rdata, last_rerr); end
    endtask

    task automatic test_back_to_back;
        logic got;
        a_src_log.delete();
        req_we = 1'b1; req_funct3 = 3'd2;
        for (int i = 0; i < 4; i++) begin
            req_addr  = 10'h100 + 10'(i * 4);
            req_wdata = 32'hA000_0000 + 32'(i);
            req_valid = 1'b1;
            @(negedge clk);
            num_vec++; if (req_ready !== 1'b1) begin num_err++; $display("FAIL b2b_ready%0d: got %b want 1", i, req_ready); end
            @(posedge clk);
            #1;
        end
        req_addr = 10'h200; req_wdata = 32'h5555_AAAA;
        @(negedge clk);
        num_vec++; if (req_ready !== 1'b0) begin num_err++; $display("FAIL b2b_full: got req_ready=%b want 0", req_ready); end
        @(posedge clk);
        #1;
        send_d(3'd0, 2'd2, 1'b0, 32'h0);
        @(negedge clk);
        num_vec++; if (req_ready !== 1'b1) begin num_err++; $display("FAIL b2b_reuse_ready: got %b want 1", req_ready); end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 5 && !got; i++) begin
            @(negedge clk);
            if (a_valid) got = 1'b1;
        end
        num_vec++; if (!got || a_channel[47:46] !== 2'd2)
            begin num_err++; $display("FAIL b2b_reuse_src: got a=%b src=%0d want 1 2", got, a_channel[47:46]); end
        num_vec++; if (a_src_log.size() < 4 || a_src_log[0] !== 2'd0 || a_src_log[1] !== 2'd1 || a_src_log[2] !== 2'd2 || a_src_log[3] !== 2'd3)
            begin num_err++; $display("FAIL b2b_order: got %0d beats, sources not 0,1,2,3", a_src_log.size()); end
        @(posedge clk);
        #1;
        send_d(3'd0, 2'd0, 1'b0, 32'h0);
        send_d(3'd0, 2'd1, 1'b0, 32'h0);
        send_d(3'd0, 2'd2, 1'b0, 32'h0);
        send_d(3'd0, 2'd3, 1'b0, 32'h0);
        tick(2);
        num_vec++; if (busy !== 1'b0) begin num_err++; $display("FAIL b2b_drain_busy: got %b want 0", busy); end
    endtask

    task automatic test_retry;
        int c1, r0;
        issue_req(1'b0, 3'd2, 10'h040, 32'h0);
        tick(2);
        c1 = a_cnt[1]; r0 = resp_cnt;
        issue_req(1'b0, 3'd2, 10'h080, 32'h0);
        tick(3);
        num_vec++; if (a_cnt[1] !== c1 + 1) begin num_err++; $display("FAIL retry_first_issue: got %0d beats want 1", a_cnt[1] - c1); end
        send_d(3'd1, 2'd1, 1'b1, 32'h0);
        tick(4);
        send_d(3'd1, 2'd1, 1'b1, 32'h0);
        tick(4);
        num_vec++; if (a_cnt[1] !== c1 + 3 || resp_cnt !== r0)
            begin num_err++; $display("FAIL retry_reissue: got beats=%0d resps=%0d want 3 0", a_cnt[1] - c1, resp_cnt - r0); end
        send_d(3'd1, 2'd1, 1'b1, 32'h0);
        tick(4);
        num_vec++; if (a_cnt[1] !== c1 + 3 || resp_cnt !== r0 + 1 || last_rerr !== 1'b1 || last_rsrc !== 2'd1)
            begin num_err++; $display("FAIL retry_exhaust: got beats=%0d resps=%0d e=%b s=%0d want 3 1 1 1", a_cnt[1] - c1, resp_cnt - r0, last_rerr, last_rsrc); end
        c1 = a_cnt[1]; r0 = resp_cnt;
        issue_req(1'b0, 3'd2, 10'h084, 32'h0);
        tick(3);
        send_d(3'd1, 2'd1, 1'b1, 32'h0);
        tick(4);
        send_d(3'd1, 2'd1, 1'b1, 32'h0);
        tick(4);
        send_d(3'd1, 2'd1, 1'b0, 32'h11223344);
        tick(2);
        num_vec++; if (a_cnt[1] !== c1 + 3 || resp_cnt !== r0 + 1 || last_rerr !== 1'b0 || last_rdata !== 32'h11223344)
            begin num_err++; $display("FAIL retry_recover: got beats=%0d resps=%0d e=%b d=%h want 3 1 0 11223344", a_cnt[1] - c1, resp_cnt - r0, last_rerr, last_rdata); end
        send_d(3'd1, 2'd0, 1'b0, 32'h0);
        tick(2);
        num_vec++; if (busy !== 1'b0) begin num_err++; $display("FAIL retry_drain_busy: got %b want 0", busy); end
    endtask

    task automatic test_illegal_spurious;
        int a0, r0, s0;
        a0 = a_total; r0 = resp_cnt;
        issue_req(1'b0, 3'd2, 10'h002, 32'h0);
        @(negedge clk);
        num_vec++; if (resp_valid !== 1'b1 || resp_error !== 1'b1)
            begin num_err++; $display("FAIL illegal_resp: got v=%b e=%b want 1 1", resp_valid, resp_error); end
        num_vec++; if (d_ready !== 1'b0) begin num_err++; $display("FAIL illegal_d_ready: got %b want 0", d_ready); end
        @(posedge clk);
        #1;
        @(negedge clk);
        num_vec++; if (d_ready !== 1'b1 || resp_valid !== 1'b0)
            begin num_err++; $display("FAIL illegal_after: got d_ready=%b resp_valid=%b want 1 0", d_ready, resp_valid); end
        tick(3);
        num_vec++; if (a_total !== a0 || resp_cnt !== r0 + 1)
            begin num_err++; $display("FAIL illegal_no_beat: got beats=%0d resps=%0d want 0 1", a_total - a0, resp_cnt - r0); end
        s0 = spur_cnt; r0 = resp_cnt;
        send_d(3'd1, 2'd3, 1'b0, 32'h5);
        tick(2);
        num_vec++; if (spur_cnt !== s0 + 1 || resp_cnt !== r0)
            begin num_err++; $display("FAIL spurious_idle: got spur=%0d resps=%0d want 1 0", spur_cnt - s0, resp_cnt - r0); end
    endtask

    task automatic test_reset_midop;
        int s0;
        issue_req(1'b0, 3'd2, 10'h010, 32'h0);
        issue_req(1'b0, 3'd2, 10'h014, 32'h0);
        tick(3);
        num_vec++; if (busy !== 1'b1) begin num_err++; $display("FAIL midrst_busy_before: got %b want 1", busy); end
        reset = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        @(negedge clk);
        num_vec++; if (a_valid !== 1'b0 || a_channel !== 60'd0 || d_ready !== 1'b0)
            begin num_err++; $display("FAIL midrst_a_d: got a_valid=%b a_channel=%h d_ready=%b want 0 0 0", a_valid, a_channel, d_ready); end
        num_vec++; if (busy !== 1'b0 || resp_valid !== 1'b0 || spurious !== 1'b0)
            begin num_err++; $display("FAIL midrst_status: got busy=%b resp=%b spur=%b want 0 0 0", busy, resp_valid, spurious); end
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick(2);
        s0 = spur_cnt;
        send_d(3'd1, 2'd0, 1'b0, 32'h0);
        tick(2);
        num_vec++; if (spur_cnt !== s0 + 1 || busy !== 1'b0)
            begin num_err++; $display("FAIL midrst_stale_d: got spur=%0d busy=%b want 1 0", spur_cnt - s0, busy); end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_lb_lbu();
        test_sh();
        test_back_to_back();
        test_retry();
        test_illegal_spurious();
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", num_vec, num_err);
        $finish;
    end

endmodule

`default_nettype wire
